// File: rtl/memory_block_ram_pkg.sv
// Shared widths, lane type and address-decode helper for the CPU data memory.
package mem_pkg;

    localparam int WORD_W = 32;
    localparam int BYTE_W = 8;

    typedef logic [1:0] lane_t;

    // Drops the two lane bits and keeps only idx_w word-index bits, so any
    // address above the populated range aliases back into it.
    function automatic logic [31:0] word_index(input logic [31:0] addr, input int idx_w);
        logic [31:0] mask;
        mask = (32'd1 << idx_w) - 32'd1;
        return (addr >> 2) & mask;
    endfunction

    function automatic lane_t lane_of(input logic [31:0] addr);
        return addr[1:0];
    endfunction

endpackage

// File: rtl/memory_block_ram_if.sv
// Load/store bus between the CPU datapath and the data memory.
interface memory_block_ram_if #(
    parameter int ADDR_W = 18
);
    import mem_pkg::*;

    logic [WORD_W-1:0] read_data;
    logic              byteOperations;
    logic [ADDR_W-1:0] address;
    logic [WORD_W-1:0] write_data;
    logic              memRead;
    logic              memWrite;

    modport master (
        input  read_data,
        output byteOperations,
        output address,
        output write_data,
        output memRead,
        output memWrite
    );

    modport slave (
        output read_data,
        input  byteOperations,
        input  address,
        input  write_data,
        input  memRead,
        input  memWrite
    );

endinterface

// File: rtl/memory_block_ram_byte_lane_merge.sv
// Replaces one little-endian byte lane of a word, leaving the other lanes intact.
module memory_block_ram_byte_lane_merge
    import mem_pkg::*;
(
    input  logic [WORD_W-1:0] old_word,
    input  logic [BYTE_W-1:0] new_byte,
    input  lane_t             lane,
    output logic [WORD_W-1:0] merged_word
);

    always_comb begin
        merged_word = old_word;
        unique case (lane)
            2'd0: merged_word[7:0]   = new_byte;
            2'd1: merged_word[15:8]  = new_byte;
            2'd2: merged_word[23:16] = new_byte;
            2'd3: merged_word[31:24] = new_byte;
            default: merged_word = old_word;
        endcase
    end

endmodule

// File: rtl/memory_block_ram.sv
// Single-port byte-addressed data memory: synchronous writes, registered reads,
// word or zero-extended byte accesses, read-before-write on a combined access.
module memory_block_ram
    import mem_pkg::*;
#(
    parameter int ADDR_W      = 18,
    parameter int DEPTH_WORDS = 256
) (
    input  logic              clk,
    input  logic              reset,
    memory_block_ram_if.slave bus
);

    localparam int IDX_W = $clog2(DEPTH_WORDS);

    logic [WORD_W-1:0] mem [DEPTH_WORDS];

    logic [IDX_W-1:0]  widx;
    lane_t             lane;
    logic [WORD_W-1:0] cur_word;
    logic [BYTE_W-1:0] cur_byte;
    logic [WORD_W-1:0] merged_word;
    logic [WORD_W-1:0] wr_word;
    logic [WORD_W-1:0] rd_word;

    assign widx     = IDX_W'(word_index(32'(bus.address), IDX_W));
    assign lane     = lane_of(32'(bus.address));
    assign cur_word = mem[widx];

    always_comb begin
        cur_byte = cur_word[7:0];
        unique case (lane)
            2'd0: cur_byte = cur_word[7:0];
            2'd1: cur_byte = cur_word[15:8];
            2'd2: cur_byte = cur_word[23:16];
            2'd3: cur_byte = cur_word[31:24];
            default: cur_byte = cur_word[7:0];
        endcase
    end

    memory_block_ram_byte_lane_merge u_merge (
        .old_word    (cur_word),
        .new_byte    (bus.write_data[BYTE_W-1:0]),
        .lane        (lane),
        .merged_word (merged_word)
    );

    assign wr_word = bus.byteOperations ? merged_word : bus.write_data;
    assign rd_word = bus.byteOperations ? {{(WORD_W-BYTE_W){1'b0}}, cur_byte} : cur_word;

    // Read samples cur_word before the write lands, giving read-before-write.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bus.read_data <= '0;
            for (int i = 0; i < DEPTH_WORDS; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (bus.memRead) begin
                bus.read_data <= rd_word;
            end
            if (bus.memWrite) begin
                mem[widx] <= wr_word;
            end
        end
    end

endmodule

// File: tb/tb_memory_block_ram.sv
// Directed bench for the CPU data memory with hand-computed expected values.
module tb_memory_block_ram;

    localparam int ADDR_W      = 18;
    localparam int DEPTH_WORDS = 256;

    logic clk;
    logic reset;
    int   n_cmp;
    int   n_bad;

    memory_block_ram_if #(.ADDR_W(ADDR_W)) bus ();

    memory_block_ram #(
        .ADDR_W      (ADDR_W),
        .DEPTH_WORDS (DEPTH_WORDS)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
        end
    endtask

    // One access: drive between edges, let one rising edge sample it, then idle.
    task automatic access(input logic rd, input logic wr, input logic bop,
                          input logic [ADDR_W-1:0] a, input logic [31:0] d);
        bus.memRead        = rd;
        bus.memWrite       = wr;
        bus.byteOperations = bop;
        bus.address        = a;
        bus.write_data     = d;
        @(posedge clk);
        #1;
        bus.memRead  = 1'b0;
        bus.memWrite = 1'b0;
    endtask

    task automatic wr_word(input logic [ADDR_W-1:0] a, input logic [31:0] d);
        access(1'b0, 1'b1, 1'b0, a, d);
    endtask

    task automatic rd_check(input string tag, input logic bop, input logic [ADDR_W-1:0] a,
                            input logic [31:0] exp);
        access(1'b1, 1'b0, bop, a, 32'h0);
        check32(tag, bus.read_data, exp);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        n_cmp = 0;
        n_bad = 0;
        reset = 1'b1;
        bus.memRead = 1'b0;
        bus.memWrite = 1'b0;
        bus.byteOperations = 1'b0;
        bus.address = '0;
        bus.write_data = '0;
        repeat (2) @(posedge clk);
        #1;
        check32("reset_rd", bus.read_data, 32'h0);
        reset = 1'b0;

        rd_check("rd0_after_reset", 1'b0, 18'd0, 32'h0000_0000);

        wr_word(18'd0, 32'hFFFF_FFFF);
        wr_word(18'd8, 32'hFFFF_FFFF);
        rd_check("word_rd8", 1'b0, 18'd8, 32'hFFFF_FFFF);
        rd_check("word_rd4", 1'b0, 18'd4, 32'h0000_0000);
        rd_check("word_rd0", 1'b0, 18'd0, 32'hFFFF_FFFF);

        wr_word(18'd16, 32'h1122_3344);
        rd_check("byte_rd16", 1'b1, 18'd16, 32'h0000_0044);
        rd_check("byte_rd17", 1'b1, 18'd17, 32'h0000_0033);
        rd_check("byte_rd18", 1'b1, 18'd18, 32'h0000_0022);
        rd_check("byte_rd19", 1'b1, 18'd19, 32'h0000_0011);
        rd_check("unaligned_word_rd17", 1'b0, 18'd17, 32'h1122_3344);

        access(1'b0, 1'b1, 1'b1, 18'd18, 32'hFFFF_FFAB);
        rd_check("byte_merge", 1'b0, 18'd16, 32'h11AB_3344);
        access(1'b0, 1'b1, 1'b1, 18'd19, 32'h0000_0055);
        rd_check("byte_merge_lane3", 1'b0, 18'd16, 32'h55AB_3344);

        access(1'b1, 1'b1, 1'b0, 18'd8, 32'h1234_5678);
        check32("rbw_old", bus.read_data, 32'hFFFF_FFFF);
        rd_check("rbw_new", 1'b0, 18'd8, 32'h1234_5678);

        wr_word(18'd4, 32'hCAFE_BABE);
        rd_check("alias_rd", 1'b0, 18'(4 + DEPTH_WORDS * 4), 32'hCAFE_BABE);
        access(1'b0, 1'b0, 1'b0, 18'd16, 32'h0);
        check32("hold_no_rd", bus.read_data, 32'hCAFE_BABE);
        wr_word(18'(8 + DEPTH_WORDS * 4 * 3), 32'h0BAD_F00D);
        check32("hold_wr_only", bus.read_data, 32'hCAFE_BABE);
        rd_check("alias_wr", 1'b0, 18'd8, 32'h0BAD_F00D);

        // Mid-run reset with a write pending: output clears before any edge.
        #2;
        bus.memWrite   = 1'b1;
        bus.address    = 18'd20;
        bus.write_data = 32'hDEAD_BEEF;
        reset = 1'b1;
        #1;
        check32("async_reset_rd", bus.read_data, 32'h0);
        @(posedge clk);
        #1;
        bus.memWrite = 1'b0;
        reset = 1'b0;
        rd_check("post_reset_w4", 1'b0, 18'd4, 32'h0);
        rd_check("post_reset_w16", 1'b0, 18'd16, 32'h0);
        rd_check("post_reset_w20", 1'b0, 18'd20, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
